// File: rtl/inst_decode_sequencer_if.sv
// Handshake and status bundle between the instruction source / execute unit and
// inst_decode_sequencer. The sequencer connects through the slave modport.
interface inst_decode_sequencer_if;
    logic        io_inst_valid;
    logic        io_inst_ready;
    logic [31:0] io_inst_bits;
    logic        io_issue_valid;
    logic        io_issue_ready;
    logic [2:0]  io_issue_op;
    logic [31:0] io_issue_inst;
    logic        io_exec_done;
    logic        io_illegal;
    logic        io_busy;
    logic [7:0]  io_retired;
    logic        io_timeout;

    modport master (
        output io_inst_valid, io_inst_bits, io_issue_ready, io_exec_done,
        input  io_inst_ready, io_issue_valid, io_issue_op, io_issue_inst,
               io_illegal, io_busy, io_retired, io_timeout
    );

    modport slave (
        input  io_inst_valid, io_inst_bits, io_issue_ready, io_exec_done,
        output io_inst_ready, io_issue_valid, io_issue_op, io_issue_inst,
               io_illegal, io_busy, io_retired, io_timeout
    );
endinterface

// File: rtl/inst_decode_sequencer.sv
// Instruction front end: small input FIFO, two-pattern decode and one-at-a-time issue.
// Optional WAIT_B watchdog is compiled in with INST_DECODE_SEQUENCER_TIMEOUT_EN.
module inst_decode_sequencer #(
    parameter logic [31:0] MATCH_A   = 32'h0000_257b,
    parameter logic [31:0] MATCH_B   = 32'h0000_277b,
    parameter int          QDEPTH    = 2
`ifdef INST_DECODE_SEQUENCER_TIMEOUT_EN
    ,
    parameter int          B_TIMEOUT = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    inst_decode_sequencer_if.slave  bus
);
    localparam int            PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(QDEPTH);
    localparam logic [2:0]    OP_NONE   = 3'h0;
    localparam logic [2:0]    OP_A      = 3'h1;
    localparam logic [2:0]    OP_B      = 3'h4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_B,
        ILLEGAL
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          live_q, live_d;
    logic [7:0]    retired_q, retired_d;

    logic          inst_ready;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          retire;
    logic          timeout_hit;
    logic [31:0]   head;
    logic [2:0]    head_op;
    logic          issue_valid;
    logic [2:0]    issue_op;
    logic [31:0]   issue_inst;
    logic          illegal;

    // Ready comes from registered state only; live_q keeps it low until the first edge after reset.
    always_comb begin
        full       = (count_q == DEPTH_CNT);
        empty      = (count_q == '0);
        inst_ready = live_q && !full;
        push       = bus.io_inst_valid && inst_ready;
        head       = mem_q[rd_ptr_q];
        if (head == MATCH_A) begin
            head_op = OP_A;
        end else if (head == MATCH_B) begin
            head_op = OP_B;
        end else begin
            head_op = OP_NONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = (head_op == OP_NONE) ? ILLEGAL : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.io_issue_ready) begin
                    state_d = (head_op == OP_B) ? WAIT_B : IDLE;
                end
            end
            WAIT_B: begin
                if (bus.io_exec_done || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            ILLEGAL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_valid = 1'b0;
        issue_op    = OP_NONE;
        issue_inst  = 32'h0;
        illegal     = 1'b0;
        pop         = 1'b0;
        retire      = 1'b0;
        case (state_q)
            ISSUE: begin
                issue_valid = 1'b1;
                issue_op    = head_op;
                issue_inst  = head;
                pop         = bus.io_issue_ready;
                retire      = bus.io_issue_ready && (head_op == OP_A);
            end
            WAIT_B: retire = bus.io_exec_done;
            ILLEGAL: begin
                illegal = 1'b1;
                pop     = 1'b1;
            end
            default: ;
        endcase
    end

    // Pointers are PW bits wide, so wrapping modulo QDEPTH is free.
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        live_d    = 1'b1;
        retired_d = retire ? retired_q + 8'd1 : retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            live_q    <= 1'b0;
            retired_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            live_q    <= live_d;
            retired_q <= retired_d;
        end
    end

    // Storage needs no reset: occupancy alone decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.io_inst_bits;
        end
    end

`ifdef INST_DECODE_SEQUENCER_TIMEOUT_EN
    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    // A completion arriving in the final WAIT_B cycle wins over the watchdog.
    always_comb begin
        wait_cnt_d  = (state_q == WAIT_B) ? wait_cnt_q + 5'd1 : 5'd0;
        timeout_hit = (state_q == WAIT_B) && !bus.io_exec_done &&
                      (wait_cnt_q == 5'(B_TIMEOUT - 1));
        timeout_d   = timeout_q || timeout_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 5'd0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.io_timeout = timeout_q;
`else
    assign timeout_hit    = 1'b0;
    assign bus.io_timeout = 1'b0;
`endif

    assign bus.io_inst_ready  = inst_ready;
    assign bus.io_issue_valid = issue_valid;
    assign bus.io_issue_op    = issue_op;
    assign bus.io_issue_inst  = issue_inst;
    assign bus.io_illegal     = illegal;
    assign bus.io_busy        = (state_q != IDLE);
    assign bus.io_retired     = retired_q;
endmodule

// File: doc/inst_decode_sequencer.md
Name: inst_decode_sequencer

Overview:
- Front-end controller that accepts 32-bit instructions over a valid/ready handshake and buffers them in a small FIFO.
- Decodes the head entry against two fixed match patterns and issues each legal instruction, one at a time, to a downstream execute unit.
- Single-cycle ops retire on issue. Multi-cycle ops hold the sequencer until the execute unit reports completion. Illegal encodings are flagged and dropped.

Parameters:
- MATCH_A, 32'h257b, encoding of class-A (single-cycle) op; decodes to op code 3'h1.
- MATCH_B, 32'h277b, encoding of class-B (multi-cycle) op; decodes to op code 3'h4.
- QDEPTH, 2, input FIFO depth (power of two, >= 2).
- B_TIMEOUT, 16, maximum WAIT_B cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_inst_valid  input  1  upstream instruction valid.
- io_inst_ready  output  1  FIFO can accept; equals !full, registered-state only.
- io_inst_bits  input  32  instruction word.
- io_issue_valid  output  1  issue request to execute unit.
- io_issue_ready  input  1  execute unit accepts the issue.
- io_issue_op  output  3  decoded op code (3'h1 or 3'h4); 3'h0 when not issuing.
- io_issue_inst  output  32  head instruction; 32'h0 when not issuing.
- io_exec_done  input  1  one-cycle pulse: class-B op finished.
- io_illegal  output  1  one-cycle pulse: head instruction dropped as illegal.
- io_busy  output  1  high in any state other than IDLE.
- io_retired  output  8  retired-instruction counter, wraps 8'hff -> 8'h00.
- io_timeout  output  1  sticky watchdog flag (see Optional Feature).

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is asynchronous and active-high. While reset is asserted, FIFO empty, state IDLE, io_retired=0, io_timeout=0, all valid/pulse outputs 0, io_inst_ready=0. io_inst_ready rises the first cycle after reset deasserts. Reset mid-operation discards FIFO contents and any in-flight op; no completion is counted.
- FIFO: push on io_inst_valid && io_inst_ready. Pop only as listed per state below.
  - io_inst_ready depends on occupancy only, not on same-cycle pop, so a full FIFO refuses input even in a pop cycle.
  - A push and a pop in the same cycle keep occupancy unchanged.
  - Pointers wrap modulo QDEPTH.
- Decode of FIFO head, combinational:
  - head==MATCH_A -> op 3'h1.
  - head==MATCH_B -> op 3'h4.
  - else op 3'h0 (illegal).
- FSM, states IDLE, ISSUE, WAIT_B, ILLEGAL:
  - IDLE: FIFO empty -> stay. Head op==0 -> ILLEGAL. Else -> ISSUE.
  - ISSUE: io_issue_valid=1, io_issue_op/io_issue_inst driven from head. Hold all three stable until io_issue_ready.
    - On handshake with op 3'h1: pop, io_retired+1, -> IDLE.
    - On handshake with op 3'h4: pop, -> WAIT_B.
  - WAIT_B: io_issue_valid=0; wait for io_exec_done. On it: io_retired+1, -> IDLE. io_exec_done in any other state is ignored.
  - ILLEGAL: io_illegal=1 for exactly this cycle; pop; -> IDLE. io_retired unchanged.
- Latency: an instruction accepted in cycle N sits in IDLE decode at N+1 and reaches ISSUE or ILLEGAL at N+2. Minimum spacing between back-to-back class-A issues is 2 cycles (ISSUE -> IDLE -> ISSUE).
- io_busy = (state != IDLE).

Optional Feature:
- Macro: INST_DECODE_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A 5-bit counter clears on WAIT_B entry and increments each WAIT_B cycle.
  - When it reaches B_TIMEOUT without io_exec_done: set io_timeout (sticky until reset), -> IDLE, no retire.
  - io_exec_done in the same cycle as the timeout takes priority: retire, io_timeout not set.
- Not defined: no counter; WAIT_B waits indefinitely; io_timeout tied 0.

Test Plan:
- Push 32'h257b with io_issue_ready=1 -> io_issue_valid high 2 cycles after acceptance with op 3'h1, inst 32'h257b; io_retired 0->1; io_busy low again next cycle.
- Push 32'h277b, assert io_exec_done 5 cycles after issue -> op 3'h4 issued; io_busy high throughout WAIT_B; io_retired increments only in the io_exec_done cycle.
- Push 32'h0000_0013 -> io_illegal single-cycle pulse 2 cycles after acceptance; no issue; io_retired unchanged.
- Hold io_issue_ready=0 and push 3 words (QDEPTH=2) -> io_inst_ready low after 2 accepted; third word is accepted only after the head issues and pops; issue outputs stay stable while stalled.
- Assert reset while in WAIT_B with 1 entry queued -> all outputs 0 immediately (async); after release, FIFO empty, state IDLE, io_retired=0.
- With TIMEOUT_EN, issue 32'h277b and never pulse io_exec_done -> io_timeout set after 16 WAIT_B cycles, state IDLE, io_retired unchanged; without the macro, io_busy stays high indefinitely.
